// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit and its
// consumers (ALU control decoder, datapath muxes).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_RTYPEEX = 4'd7,
        ST_RTYPEWB = 4'd8,
        ST_BEQEX   = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_JEX     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Must stay in step with the ALU control decoder's alu_op interpretation.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that wait on mem_ready and are therefore subject to the timeout.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: state (plus mem_ready qualifier in FETCH) to the
// datapath control word. Unused/reserved state codes yield all zeros.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // PC and IR only load on the cycle the fetch actually completes.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_RTYPEEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ST_RTYPEWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            ST_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_BEQEX: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_JEX: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM with memory-wait timeout; produces the
// per-cycle datapath control word and alu_op for the ALU control decoder.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_wait;
    logic       timeout;
    ctrl_t      ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        mem_wait   = is_mem_state(state_q) && !mem_ready;
        timeout    = TIMEOUT_EN && mem_wait && (wait_cnt_q == TIMEOUT_CNT);

        case (state_q)
            ST_RESET:   state_d = ST_FETCH;
            ST_FETCH:   if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_RTYPEEX;
                    OP_BEQ:       state_d = ST_BEQEX;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JEX;
                    default: begin
                        state_d    = ST_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            // Anything other than sw reads: a spurious read is harmless, a write is not.
            ST_MEMADR:  state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:   if (mem_ready) state_d = ST_FETCH;
            ST_RTYPEEX: state_d = ST_RTYPEWB;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            default:    state_d = ST_FETCH;
        endcase

        if (timeout) begin
            state_d = ST_FETCH;
            mem_err = 1'b1;
        end

        // A timeout in FETCH re-enters FETCH, so it must clear explicitly.
        if (timeout || (state_d != state_q)) begin
            wait_cnt_d = 8'd0;
        end else if (mem_wait && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes per-cycle expectations from
// an instruction-path reference model; a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

    localparam int TMO = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_err;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_err;
    logic [3:0] state;

    mc_ctrl_fsm #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .mem_err       (mem_err),
        .state         (state)
    );

    always #5 clk = ~clk;

    obs_t dut_o;
    assign dut_o = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op, mem_err};

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t sb_q[$];

    task automatic check(input string name, input obs_t got, input obs_t req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s @%0t: got st=%0d ctl=%h, required st=%0d ctl=%h",
                      name, $time, got.st, got[17:0], req.st, req[17:0]);
    endtask

    // ---------------- reference model ----------------
    int m_seq[$];
    int m_pos, m_wait, m_cycles;
    bit m_in_reset;

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {LW, SW, RTY, BEQ, ADDI, JMP};
    endfunction

    // Per-state control word taken straight from the output table.
    function automatic obs_t spec_outputs(input int st, input logic mr, input logic ill, input logic err);
        obs_t o = '0;
        o.st = 4'(st);
        case (st)
            1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            2:  o.alu_src_b = 2'b11;
            3, 10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4:  begin o.mem_read = 1; o.iord = 1; end
            5:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            6:  begin o.mem_write = 1; o.iord = 1; end
            7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            8:  begin o.reg_dst = 1; o.reg_write = 1; end
            9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            11: o.reg_write = 1;
            12: begin o.pc_write = 1; o.pc_source = 2'b10; end
            default: ;
        endcase
        o.illegal_op = ill;
        o.mem_err    = err;
        return o;
    endfunction

    task automatic build_path(input logic [5:0] op);
        case (op)
            LW:      m_seq = {1, 2, 3, 4, 5};
            SW:      m_seq = {1, 2, 3, 6};
            RTY:     m_seq = {1, 2, 7, 8};
            BEQ:     m_seq = {1, 2, 9};
            ADDI:    m_seq = {1, 2, 10, 11};
            JMP:     m_seq = {1, 2, 12};
            default: m_seq = {1, 2};
        endcase
    endtask

    task automatic model_cycle(input logic [5:0] op, input logic mr, output obs_t e, output bit instr_end);
        int cur;
        bit is_mem, tmo, ill;
        instr_end = 0;
        if (m_in_reset) begin
            e = spec_outputs(0, 1'b0, 1'b0, 1'b0);
            m_in_reset = 0;
            m_seq.delete();
            return;
        end
        if (m_seq.size() == 0) begin
            build_path(op);
            m_pos = 0; m_wait = 0; m_cycles = 0;
        end
        cur = m_seq[m_pos];
        m_cycles++;
        is_mem = (cur == 1) || (cur == 4) || (cur == 6);
        tmo    = is_mem && !mr && (TMO != 0) && (m_wait == TMO);
        ill    = (cur == 2) && !is_legal(op);
        e = spec_outputs(cur, mr, ill, tmo);
        if (tmo) begin
            m_seq.delete();
            instr_end = 1;
        end else if (is_mem && !mr) begin
            m_wait++;
        end else begin
            m_pos++;
            m_wait = 0;
            if (m_pos >= m_seq.size()) begin
                m_seq.delete();
                instr_end = 1;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic cycle(input logic [5:0] op, input logic mr, output bit done);
        obs_t e;
        opcode    = op;
        mem_ready = mr;
        model_cycle(op, mr, e, done);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int zero_pct);
        bit done = 0;
        int n = 0;
        while (!done && n < 200) begin
            cycle(op, ($urandom_range(0, 99) >= zero_pct), done);
            n++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL instr_bound: op=%b did not complete in %0d cycles, required completion", op, n);
        end
        $display("instr op=%b stall%%=%0d cycles=%0d", op, zero_pct, n);
    endtask

    task automatic cycles_n(input logic [5:0] op, input logic mr, input int n);
        bit d;
        for (int i = 0; i < n; i++) cycle(op, mr, d);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("cycle", dut_o, e);
        end
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        int         biases[3];
        obs_t       zero_obs;
        ops       = '{LW, SW, RTY, BEQ, ADDI, JMP};
        biases    = '{0, 20, 85};
        zero_obs  = '0;
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        m_in_reset = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", dut_o, zero_obs);
        rst_n = 1'b1;

        // Basic paths with mem_ready held high.
        run_instr(LW, 0);
        run_instr(RTY, 0);
        run_instr(BEQ, 0);
        run_instr(JMP, 0);
        run_instr(SW, 0);
        run_instr(ADDI, 0);
        run_instr(BAD, 0);

        // Fetch stall then completion.
        cycles_n(RTY, 1'b0, 3);
        run_instr(RTY, 0);

        // MEMWR timeout, then mem_ready arriving exactly at the limit.
        cycles_n(SW, 1'b1, 3);
        cycles_n(SW, 1'b0, TMO + 1);
        cycles_n(SW, 1'b1, 3);
        cycles_n(SW, 1'b0, TMO);
        cycles_n(SW, 1'b1, 1);

        // FETCH timeout restarts FETCH; counter must restart as well.
        cycles_n(LW, 1'b0, 2 * (TMO + 1));
        run_instr(LW, 0);

        // Asynchronous reset while stalled in MEMRD.
        cycles_n(LW, 1'b1, 3);
        cycles_n(LW, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_o, zero_obs);
        @(posedge clk);
        #1;
        check("reset_held", dut_o, zero_obs);
        m_in_reset = 1;
        m_seq.delete();
        rst_n = 1'b1;
        run_instr(LW, 0);

        // Randomized instruction stream with varying memory stall density.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, biases[$urandom_range(0, 2)]);
        end

        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle MIPS main control unit. It is the producing end of the alu_op interface that the ALU control decoder consumes, and it sequences every datapath enable per cycle. It is a Moore FSM, plus memory-handshake qualification on write strobes. It sits between the IR opcode field, the memory ready line, and all multicycle datapath muxes and enables.

Parameters:
TIMEOUT, 15, max mem_ready-low cycles tolerated in one memory state before abort; range 1..255; 0 disables the timeout.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; sampled only in DECODE/MEMADR
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  1 = MDR to regfile write data
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  regfile write enable
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  pulse: unsupported opcode in DECODE
mem_err  out  1  pulse: memory timeout abort
state  out  4  current state encoding (debug)

Behaviour:
- States (4-bit): RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPEEX=7, RTYPEWB=8, BEQEX=9, ADDIEX=10, ADDIWB=11, JEX=12. Codes 13-15 go to FETCH on the next edge; all outputs are 0 in those codes.
- rst_n low: state=RESET immediately, wait counter cleared. In RESET every output is 0. RESET always goes to FETCH on the first edge after release. Reset mid-instruction aborts it; no write strobe is asserted while in RESET.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Transitions:
  - FETCH goes to DECODE on mem_ready, else holds.
  - DECODE goes to MEMADR (lw/sw), RTYPEEX, BEQEX, ADDIEX or JEX. Any other opcode returns to FETCH with illegal_op=1 for that cycle.
  - MEMADR goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD goes to MEMWB on mem_ready, else holds. MEMWR goes to FETCH on mem_ready, else holds.
  - RTYPEEX goes to RTYPEWB. ADDIEX goes to ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX go to FETCH.
- Outputs per state (all unlisted outputs are 0):
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready (combinational qualifier).
  - DECODE: alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, iord=1.
  - MEMWR: mem_write=1, iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RTYPEWB: reg_dst=1, reg_write=1.
  - ADDIWB: reg_write=1.
  - BEQEX: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JEX: pc_write=1, pc_source=10.
- Latency with mem_ready held high:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 2 cycles.
- Wait counter (8-bit):
  - Clears on every state change.
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0.
  - Timeout condition: TIMEOUT!=0, wait_cnt==TIMEOUT and mem_ready=0. When it fires, mem_err=1 that cycle, next state=FETCH, and the counter clears.
  - A FETCH timeout re-enters FETCH; this counts as a state change, so the counter restarts.
  - mem_ready=1 in the same cycle as wait_cnt==TIMEOUT takes the normal transition; mem_err stays 0.
- illegal_op and mem_err are combinational from state, opcode, mem_ready and counter. They are never asserted in the same cycle.

Decomposition:
- Shared package holds:
  - opcode constants;
  - state encodings;
  - alu_op constants (ADD=00, SUB=01, FUNCT=10), matching the ALU control decoder;
  - alu_src_b and pc_source encodings.
- One sub-module, mc_ctrl_outdec: a purely combinational decode of state and mem_ready to the control word. The FSM and wait counter stay in the top.

Test Plan:
1. Reset: assert rst_n=0 while in MEMRD -> state=0 and all outputs 0 without a clock edge; release -> state=1 after the first edge; no reg_write seen.
2. lw, mem_ready=1 -> states 1,2,3,4,5,1. MEMWB has reg_write=1, mem_to_reg=1, reg_dst=0. MEMRD has iord=1.
3. R-type/beq/j sequences:
   - R-type -> 1,2,7,8; alu_op=10 in state 7; reg_dst=1 in state 8.
   - beq -> 1,2,9; alu_op=01, pc_write_cond=1, pc_source=01.
   - j -> 1,2,12; pc_write=1, pc_source=10.
4. Fetch stall: mem_ready=0 for 3 cycles in FETCH -> state holds at 1 with ir_write=pc_write=0. mem_ready=1 -> both high exactly 1 cycle, then DECODE.
5. Timeout, TIMEOUT=4: sw with mem_ready=0 in MEMWR -> 5 cycles in state 6, mem_err=1 in the 5th, then FETCH. Repeat with mem_ready=1 in the 5th cycle -> mem_err=0 and normal transition to FETCH.
6. Illegal opcode 111111 -> illegal_op=1 in DECODE, next state 1; reg_write, mem_write and pc_write_cond stay 0 throughout.
